// File: rtl/div_32.sv
// div_32: sequential 32-bit restoring divider; quotient on Y_lo, remainder on Y_hi.
// Define DIV32_SIGNED_EN to enable two's-complement division selected by sgn.
module div_32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] S,
  input  logic [31:0] T,
  output logic [31:0] Y_hi,
  output logic [31:0] Y_lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      r_state;
  logic [31:0] r_r;
  logic [31:0] r_q;
  logic [31:0] r_d;
  logic [4:0]  r_cnt;
  logic        r_dz;

  logic [31:0] w_abs_s;
  logic [31:0] w_abs_t;
  logic [31:0] w_fin_q;
  logic [31:0] w_fin_r;
  logic [32:0] w_sh;
  logic [32:0] w_sub;
  logic        w_ge;

`ifdef DIV32_SIGNED_EN
  logic r_neg_q;
  logic r_neg_r;
  logic w_neg_s;
  logic w_neg_t;

  function automatic logic [31:0] negate(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  assign w_neg_s = sgn & S[31];
  assign w_neg_t = sgn & T[31];
  assign w_abs_s = w_neg_s ? negate(S) : S;
  assign w_abs_t = w_neg_t ? negate(T) : T;
  assign w_fin_q = r_neg_q ? negate(r_q) : r_q;
  assign w_fin_r = r_neg_r ? negate(r_r) : r_r;
`else
  logic w_unused_sgn;

  assign w_unused_sgn = sgn;
  assign w_abs_s      = S;
  assign w_abs_t      = T;
  assign w_fin_q      = r_q;
  assign w_fin_r      = r_r;
`endif

  // Shifted partial remainder can reach 33 bits before the trial subtract.
  assign w_sh  = {r_r, r_q[31]};
  assign w_sub = w_sh - {1'b0, r_d};
  assign w_ge  = (w_sh >= {1'b0, r_d});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_r      <= 32'd0;
      r_q      <= 32'd0;
      r_d      <= 32'd0;
      r_cnt    <= 5'd0;
      r_dz     <= 1'b0;
      Y_hi     <= 32'd0;
      Y_lo     <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
`ifdef DIV32_SIGNED_EN
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            r_cnt <= 5'd0;
            if (T == 32'd0) begin
              // Raw dividend is parked in r_q so FIN can return it as remainder.
              r_dz    <= 1'b1;
              r_q     <= S;
              r_state <= FIN;
            end else begin
              r_dz    <= 1'b0;
              r_q     <= w_abs_s;
              r_r     <= 32'd0;
              r_d     <= w_abs_t;
              r_state <= CALC;
`ifdef DIV32_SIGNED_EN
              r_neg_q <= w_neg_s ^ w_neg_t;
              r_neg_r <= w_neg_s;
`endif
            end
          end
        end
        CALC: begin
          r_r   <= w_ge ? w_sub[31:0] : w_sh[31:0];
          r_q   <= {r_q[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= FIN;
        end
        FIN: begin
          busy     <= 1'b0;
          done     <= 1'b1;
          div_zero <= r_dz;
          r_state  <= IDLE;
          if (r_dz) begin
            Y_lo <= 32'hFFFF_FFFF;
            Y_hi <= r_q;
          end else begin
            Y_lo <= w_fin_q;
            Y_hi <= w_fin_r;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_32.sv
// tb_div_32: directed-vector bench for div_32 (signed expectations follow DIV32_SIGNED_EN).
`timescale 1ns/1ps
module tb_div_32;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sgn;
  logic [31:0] S;
  logic [31:0] T;
  logic [31:0] Y_hi;
  logic [31:0] Y_lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int n_chk = 0;
  int n_bad = 0;

  div_32 dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .sgn      (sgn),
    .S        (S),
    .T        (T),
    .Y_hi     (Y_hi),
    .Y_lo     (Y_lo),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Issue one operation sampled at edge 0, then watch 40 edges for the done pulse.
  task automatic do_op(input string tag, input logic [31:0] s, input logic [31:0] t,
                       input logic sg, input int exp_lat, input logic [31:0] exp_q,
                       input logic [31:0] exp_r, input logic exp_dz);
    int lat;
    int n_done;
    lat    = -1;
    n_done = 0;
    @(negedge clk);
    S = s; T = t; sgn = sg; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    S = ~s; T = 32'h0000_0003; sgn = ~sg;
    check_eq({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == exp_lat - 1) check_eq({tag, "_busy_pre"}, {31'd0, busy}, 32'd1);
      if (done) begin
        n_done++;
        if (lat < 0) begin
          lat = i;
          check_eq({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
        end
      end
    end
    check_eq({tag, "_lat"}, lat, exp_lat);
    check_eq({tag, "_ndone"}, n_done, 32'd1);
    check_eq({tag, "_q"}, Y_lo, exp_q);
    check_eq({tag, "_r"}, Y_hi, exp_r);
    check_eq({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
  endtask

  initial begin
    int lat;
    int n_done;
    reset = 1'b1; start = 1'b0; sgn = 1'b0; S = 32'd0; T = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_q", Y_lo, 32'd0);
    check_eq("rst_r", Y_hi, 32'd0);
    check_eq("rst_ctl", {29'd0, busy, done, div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op("u100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);
    do_op("dz", 32'h1234_5678, 32'd0, 1'b0, 1, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    do_op("u5_10", 32'd5, 32'd10, 1'b0, 33, 32'd0, 32'd5, 1'b0);
    do_op("uffff", 32'hFFFF_FFFF, 32'h0000_FFFF, 1'b0, 33, 32'h0001_0001, 32'd0, 1'b0);
    do_op("uneg7", 32'hFFFF_FFF9, 32'd2, 1'b0, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
`ifdef DIV32_SIGNED_EN
    do_op("sneg7", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    do_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'h8000_0000, 32'd0, 1'b0);
    do_op("s7_neg2", 32'd7, 32'hFFFF_FFFE, 1'b1, 33, 32'hFFFF_FFFD, 32'd1, 1'b0);
`else
    do_op("sneg7", 32'hFFFF_FFF9, 32'd2, 1'b1, 33, 32'h7FFF_FFFC, 32'd1, 1'b0);
    do_op("sovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 32'd0, 32'h8000_0000, 1'b0);
`endif

    // Back-to-back: second start held in the done cycle; stray starts while busy.
    @(negedge clk);
    S = 32'hFFFF_FFFF; T = 32'd1; sgn = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 33; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
      if (i == 10) begin S = 32'd50; T = 32'd5; start = 1'b1; end
      if (i == 12) start = 1'b0;
    end
    check_eq("b2b_first_done", n_done, 32'd1);
    check_eq("b2b_first_q", Y_lo, 32'hFFFF_FFFF);
    check_eq("b2b_first_r", Y_hi, 32'd0);
    S = 32'd9; T = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 10) begin S = 32'd8; T = 32'd2; start = 1'b1; end
      if (i == 11) start = 1'b0;
      if (done) begin
        n_done++;
        if (lat < 0) lat = i;
      end
    end
    check_eq("b2b_lat", lat, 32'd33);
    check_eq("b2b_ndone", n_done, 32'd1);
    check_eq("b2b_q", Y_lo, 32'd3);
    check_eq("b2b_r", Y_hi, 32'd0);

    // Reset at edge 15 of an operation.
    @(negedge clk);
    S = 32'd100; T = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    #1;
    check_eq("mid_rst_q", Y_lo, 32'd0);
    check_eq("mid_rst_r", Y_hi, 32'd0);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    n_done = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check_eq("mid_rst_nodone", n_done, 32'd0);
    do_op("after_rst", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
